// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared encodings and output-bundle helpers for the pipeline hazard controller.
package pipe_hazard_ctrl_pkg;

  localparam int DEF_W = 16;
  localparam int DEF_N = 3;
  localparam int CNT_W = 3;

  typedef enum logic [2:0] {
    ST_RUN       = 3'd0,
    ST_LU_STALL  = 3'd1,
    ST_INT_DRAIN = 3'd2,
    ST_INT_PUSH  = 3'd3,
    ST_INT_VEC   = 3'd4
  } state_t;

  localparam logic [1:0] PCSEL_INC = 2'd0;
  localparam logic [1:0] PCSEL_BR  = 2'd1;
  localparam logic [1:0] PCSEL_VEC = 2'd2;

  typedef struct packed {
    logic       pc_en;
    logic       fd_en;
    logic       de_en;
    logic       fd_flush;
    logic       de_flush;
    logic [1:0] pc_sel;
    logic       push_en;
    logic       push_word;
    logic       int_ack;
  } ctrl_t;

  function automatic ctrl_t ctrl_run();
    ctrl_t c;
    c.pc_en     = 1'b1;
    c.fd_en     = 1'b1;
    c.de_en     = 1'b1;
    c.fd_flush  = 1'b0;
    c.de_flush  = 1'b0;
    c.pc_sel    = PCSEL_INC;
    c.push_en   = 1'b0;
    c.push_word = 1'b0;
    c.int_ack   = 1'b0;
    return c;
  endfunction

  // Memory stall: everything frozen, nothing cleared.
  function automatic ctrl_t ctrl_idle();
    ctrl_t c;
    c        = ctrl_run();
    c.pc_en  = 1'b0;
    c.fd_en  = 1'b0;
    c.de_en  = 1'b0;
    return c;
  endfunction

  function automatic ctrl_t ctrl_bubble();
    ctrl_t c;
    c          = ctrl_run();
    c.pc_en    = 1'b0;
    c.fd_en    = 1'b0;
    c.de_flush = 1'b1;
    return c;
  endfunction

  function automatic ctrl_t ctrl_reset();
    ctrl_t c;
    c          = ctrl_idle();
    c.fd_flush = 1'b1;
    c.de_flush = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_hz_detect.sv
// Load-use comparator: a load in execute targets a register that decode reads.
module hz_detect
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int N = DEF_N
) (
  input  logic [N-1:0] d_src,
  input  logic [N-1:0] d_dst,
  input  logic         d_use_src,
  input  logic         d_use_dst,
  input  logic         ex_memRead,
  input  logic         ex_regWrite,
  input  logic [N-1:0] ex_dst,
  output logic         hz
);

  logic src_hit;
  logic dst_hit;

  assign src_hit = d_use_src & (d_src == ex_dst);
  assign dst_hit = d_use_dst & (d_dst == ex_dst);
  assign hz      = ex_memRead & ex_regWrite & (src_hit | dst_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, branch flushes, and the
// interrupt drain / return-address push / vector sequence.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int N         = DEF_N,
  parameter int LU_STALL  = 1,
  parameter int DRAIN_CYC = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] d_src,
  input  logic [N-1:0] d_dst,
  input  logic         d_use_src,
  input  logic         d_use_dst,
  input  logic         ex_memRead,
  input  logic         ex_regWrite,
  input  logic [N-1:0] ex_dst,
  input  logic         branch_taken,
  input  logic         mem_busy,
  input  logic         int_req,
  output logic         pc_en,
  output logic         fd_en,
  output logic         de_en,
  output logic         fd_flush,
  output logic         de_flush,
  output logic [1:0]   pc_sel,
  output logic         push_en,
  output logic         push_word,
  output logic         int_ack,
  output logic [2:0]   state
);

  localparam logic [CNT_W-1:0] LU_LOAD    = CNT_W'(LU_STALL - 1);
  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_t           cur_st;
  state_t           nxt_st;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] nxt_cnt;
  logic             pending;
  logic             nxt_pending;
  logic             phase;
  logic             nxt_phase;
  logic             hz;
  ctrl_t            ctl;
  ctrl_t            ctl_out;

  hz_detect #(.N(N)) u_hz_detect (
    .d_src       (d_src),
    .d_dst       (d_dst),
    .d_use_src   (d_use_src),
    .d_use_dst   (d_use_dst),
    .ex_memRead  (ex_memRead),
    .ex_regWrite (ex_regWrite),
    .ex_dst      (ex_dst),
    .hz          (hz)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_st  <= ST_RUN;
      cnt     <= '0;
      pending <= 1'b0;
      phase   <= 1'b0;
    end else begin
      cur_st  <= nxt_st;
      cnt     <= nxt_cnt;
      pending <= nxt_pending;
      phase   <= nxt_phase;
    end
  end

  // A request arriving during a memory stall is still remembered; only the
  // vector cycle can consume it.
  always_comb begin
    nxt_st      = cur_st;
    nxt_cnt     = cnt;
    nxt_phase   = phase;
    nxt_pending = pending | int_req;
    ctl         = ctrl_run();

    if (mem_busy) begin
      ctl = ctrl_idle();
    end else begin
      case (cur_st)
        ST_RUN: begin
          if (branch_taken) begin
            ctl.pc_sel   = PCSEL_BR;
            ctl.fd_flush = 1'b1;
            ctl.de_flush = 1'b1;
            nxt_cnt      = '0;
          end else if (hz) begin
            ctl     = ctrl_bubble();
            nxt_cnt = LU_LOAD;
            nxt_st  = (LU_STALL > 1) ? ST_LU_STALL : ST_RUN;
          end else if (pending) begin
            nxt_st  = ST_INT_DRAIN;
            nxt_cnt = DRAIN_LOAD;
          end
        end
        ST_LU_STALL: begin
          if (branch_taken) begin
            ctl.pc_sel   = PCSEL_BR;
            ctl.fd_flush = 1'b1;
            ctl.de_flush = 1'b1;
            nxt_cnt      = '0;
            nxt_st       = ST_RUN;
          end else begin
            ctl = ctrl_bubble();
            if (cnt <= CNT_ONE) begin
              nxt_cnt = '0;
              nxt_st  = ST_RUN;
            end else begin
              nxt_cnt = cnt - CNT_ONE;
            end
          end
        end
        // A branch resolving here redirects the PC so the return address
        // pushed afterwards is the branch target.
        ST_INT_DRAIN: begin
          ctl.pc_en    = 1'b0;
          ctl.fd_flush = 1'b1;
          if (branch_taken) begin
            ctl.pc_sel = PCSEL_BR;
            ctl.pc_en  = 1'b1;
          end
          if (cnt == '0) begin
            nxt_st    = ST_INT_PUSH;
            nxt_phase = 1'b0;
          end else begin
            nxt_cnt = cnt - CNT_ONE;
          end
        end
        ST_INT_PUSH: begin
          ctl.pc_en     = 1'b0;
          ctl.fd_flush  = 1'b1;
          ctl.de_flush  = 1'b1;
          ctl.push_en   = 1'b1;
          ctl.push_word = phase;
          if (phase) begin
            nxt_phase = 1'b0;
            nxt_st    = ST_INT_VEC;
          end else begin
            nxt_phase = 1'b1;
          end
        end
        ST_INT_VEC: begin
          ctl.pc_sel   = PCSEL_VEC;
          ctl.pc_en    = 1'b1;
          ctl.int_ack  = 1'b1;
          ctl.fd_flush = 1'b1;
          ctl.de_flush = 1'b1;
          nxt_pending  = int_req;
          nxt_cnt      = '0;
          nxt_st       = ST_RUN;
        end
        default: begin
          nxt_st    = ST_RUN;
          nxt_cnt   = '0;
          nxt_phase = 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    ctl_out = rst ? ctl : ctrl_reset();
  end

  assign pc_en     = ctl_out.pc_en;
  assign fd_en     = ctl_out.fd_en;
  assign de_en     = ctl_out.de_en;
  assign fd_flush  = ctl_out.fd_flush;
  assign de_flush  = ctl_out.de_flush;
  assign pc_sel    = ctl_out.pc_sel;
  assign push_en   = ctl_out.push_en;
  assign push_word = ctl_out.push_word;
  assign int_ack   = ctl_out.int_ack;
  assign state     = cur_st;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench: two controller instances (1-cycle and 3-cycle load-use)
// driven in lockstep and compared against a behavioural reference model.
module tb_pipe_hazard_ctrl;

  localparam int N    = 3;
  localparam int LS_A = 1;
  localparam int DC_A = 1;
  localparam int LS_B = 3;
  localparam int DC_B = 3;

  localparam int M_RUN   = 0;
  localparam int M_LU    = 1;
  localparam int M_DRAIN = 2;
  localparam int M_PUSH  = 3;
  localparam int M_VEC   = 4;

  // Bit order: pc_en fd_en de_en fd_flush de_flush pc_sel[1:0] push_en push_word int_ack state[2:0]
  typedef logic [12:0] obs_t;

  typedef struct {
    bit           rst;
    logic [N-1:0] d_src;
    logic [N-1:0] d_dst;
    logic [N-1:0] ex_dst;
    bit           d_use_src;
    bit           d_use_dst;
    bit           ex_memRead;
    bit           ex_regWrite;
    bit           branch_taken;
    bit           mem_busy;
    bit           int_req;
  } stim_t;

  typedef struct {
    int mode;
    int bubbles_left;
    int drain_left;
    int words_pushed;
    bit pending;
  } mdl_t;

  typedef struct {
    int   cyc;
    obs_t exp_a;
    obs_t exp_b;
  } sb_item_t;

  logic         clk;
  logic         rst;
  logic [N-1:0] d_src, d_dst, ex_dst;
  logic         d_use_src, d_use_dst, ex_memRead, ex_regWrite;
  logic         branch_taken, mem_busy, int_req;

  logic       a_pc_en, a_fd_en, a_de_en, a_fd_flush, a_de_flush, a_push_en, a_push_word, a_int_ack;
  logic [1:0] a_pc_sel;
  logic [2:0] a_state;
  logic       b_pc_en, b_fd_en, b_de_en, b_fd_flush, b_de_flush, b_push_en, b_push_word, b_int_ack;
  logic [1:0] b_pc_sel;
  logic [2:0] b_state;

  sb_item_t sb[$];
  mdl_t     ma, mb;
  int       cyc_count;
  int       checks;
  int       errors;
  int       model_pushes_b;
  int       dut_pushes_b;

  pipe_hazard_ctrl #(.N(N), .LU_STALL(LS_A), .DRAIN_CYC(DC_A)) u_dut_a (
    .clk(clk), .rst(rst), .d_src(d_src), .d_dst(d_dst), .d_use_src(d_use_src),
    .d_use_dst(d_use_dst), .ex_memRead(ex_memRead), .ex_regWrite(ex_regWrite),
    .ex_dst(ex_dst), .branch_taken(branch_taken), .mem_busy(mem_busy), .int_req(int_req),
    .pc_en(a_pc_en), .fd_en(a_fd_en), .de_en(a_de_en), .fd_flush(a_fd_flush),
    .de_flush(a_de_flush), .pc_sel(a_pc_sel), .push_en(a_push_en),
    .push_word(a_push_word), .int_ack(a_int_ack), .state(a_state)
  );

  pipe_hazard_ctrl #(.N(N), .LU_STALL(LS_B), .DRAIN_CYC(DC_B)) u_dut_b (
    .clk(clk), .rst(rst), .d_src(d_src), .d_dst(d_dst), .d_use_src(d_use_src),
    .d_use_dst(d_use_dst), .ex_memRead(ex_memRead), .ex_regWrite(ex_regWrite),
    .ex_dst(ex_dst), .branch_taken(branch_taken), .mem_busy(mem_busy), .int_req(int_req),
    .pc_en(b_pc_en), .fd_en(b_fd_en), .de_en(b_de_en), .fd_flush(b_fd_flush),
    .de_flush(b_de_flush), .pc_sel(b_pc_sel), .push_en(b_push_en),
    .push_word(b_push_word), .int_ack(b_int_ack), .state(b_state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: tracks remaining bubbles / drain cycles / pushed words.
  function automatic void model_step(input int lus, input int dc, input stim_t s,
                                     input mdl_t m, output mdl_t mn, output obs_t e);
    bit       pc_e, fd_e, de_e, fdf, def, pe, pw, ack, hz;
    bit [1:0] sel;
    bit [2:0] st;
    pc_e = 1; fd_e = 1; de_e = 1; fdf = 0; def = 0; sel = 2'd0; pe = 0; pw = 0; ack = 0;
    st = 3'(m.mode);
    mn = m;
    hz = s.ex_memRead && s.ex_regWrite &&
         ((s.d_use_src && s.d_src == s.ex_dst) || (s.d_use_dst && s.d_dst == s.ex_dst));
    if (!s.rst) begin
      pc_e = 0; fd_e = 0; de_e = 0; fdf = 1; def = 1; st = 3'd0;
      mn = '{M_RUN, 0, 0, 0, 1'b0};
    end else begin
      mn.pending = m.pending | s.int_req;
      if (s.mem_busy) begin
        pc_e = 0; fd_e = 0; de_e = 0;
      end else begin
        case (m.mode)
          M_RUN: begin
            if (s.branch_taken) begin
              sel = 2'd1; fdf = 1; def = 1;
            end else if (hz) begin
              pc_e = 0; fd_e = 0; def = 1;
              mn.bubbles_left = lus - 1;
              if (mn.bubbles_left > 0) mn.mode = M_LU;
            end else if (m.pending) begin
              mn.mode = M_DRAIN;
              mn.drain_left = dc;
            end
          end
          M_LU: begin
            if (s.branch_taken) begin
              sel = 2'd1; fdf = 1; def = 1;
              mn.mode = M_RUN; mn.bubbles_left = 0;
            end else begin
              pc_e = 0; fd_e = 0; def = 1;
              mn.bubbles_left = m.bubbles_left - 1;
              if (mn.bubbles_left == 0) mn.mode = M_RUN;
            end
          end
          M_DRAIN: begin
            pc_e = s.branch_taken;
            sel  = s.branch_taken ? 2'd1 : 2'd0;
            fdf  = 1;
            mn.drain_left = m.drain_left - 1;
            if (mn.drain_left == 0) begin
              mn.mode = M_PUSH; mn.words_pushed = 0;
            end
          end
          M_PUSH: begin
            pc_e = 0; fdf = 1; def = 1; pe = 1;
            pw = (m.words_pushed == 1);
            mn.words_pushed = m.words_pushed + 1;
            if (mn.words_pushed == 2) begin
              mn.mode = M_VEC; mn.words_pushed = 0;
            end
          end
          default: begin
            sel = 2'd2; ack = 1; fdf = 1; def = 1;
            mn.mode = M_RUN;
            mn.pending = s.int_req;
          end
        endcase
      end
    end
    e = {pc_e, fd_e, de_e, fdf, def, sel, pe, pw, ack, st};
  endfunction

  function automatic stim_t idle_stim();
    stim_t s;
    s = '{1'b1, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    return s;
  endfunction

  function automatic stim_t hz_stim();
    stim_t s;
    s = idle_stim();
    s.ex_memRead = 1; s.ex_regWrite = 1; s.ex_dst = 3'd3; s.d_use_src = 1; s.d_src = 3'd3;
    return s;
  endfunction

  task automatic apply_stimulus(input stim_t s);
    mdl_t     na, nb;
    obs_t     ea, eb;
    sb_item_t it;
    @(negedge clk);
    rst = s.rst; d_src = s.d_src; d_dst = s.d_dst; ex_dst = s.ex_dst;
    d_use_src = s.d_use_src; d_use_dst = s.d_use_dst;
    ex_memRead = s.ex_memRead; ex_regWrite = s.ex_regWrite;
    branch_taken = s.branch_taken; mem_busy = s.mem_busy; int_req = s.int_req;
    #1;
    model_step(LS_A, DC_A, s, ma, na, ea);
    model_step(LS_B, DC_B, s, mb, nb, eb);
    if (eb[5]) model_pushes_b++;
    ma = na;
    mb = nb;
    cyc_count++;
    it = '{cyc_count, ea, eb};
    sb.push_back(it);
  endtask

  task automatic apply_idle(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(idle_stim());
  endtask

  task automatic check_output(input string name, input int cyc, input obs_t act, input obs_t exp);
    obs_t a, x;
    a = act;
    x = exp;
    if (!x[5]) begin
      a[4] = 1'b0;
      x[4] = 1'b0;
    end
    checks++;
    if (a !== x) begin
      errors++;
      $display("[TB] FAIL %s cyc=%0d got=%b expected=%b (pc_en fd_en de_en fd_flush de_flush pc_sel push_en push_word int_ack state)",
               name, cyc, a, x);
    end
  endtask

  // Monitor: samples mid-low-phase, after the driver has queued the expectation.
  initial begin
    sb_item_t it;
    obs_t     oa, ob;
    forever begin
      @(negedge clk);
      #3;
      if (sb.size() > 0) begin
        it = sb.pop_front();
        oa = {a_pc_en, a_fd_en, a_de_en, a_fd_flush, a_de_flush, a_pc_sel,
              a_push_en, a_push_word, a_int_ack, a_state};
        ob = {b_pc_en, b_fd_en, b_de_en, b_fd_flush, b_de_flush, b_pc_sel,
              b_push_en, b_push_word, b_int_ack, b_state};
        if (b_push_en === 1'b1) dut_pushes_b++;
        check_output("dut_a", it.cyc, oa, it.exp_a);
        check_output("dut_b", it.cyc, ob, it.exp_b);
      end
    end
  end

  initial begin
    stim_t s;
    int    wait_cycles;
    checks = 0; errors = 0; cyc_count = 0; model_pushes_b = 0; dut_pushes_b = 0;
    ma = '{M_RUN, 0, 0, 0, 1'b0};
    mb = '{M_RUN, 0, 0, 0, 1'b0};
    rst = 1'b0; d_src = '0; d_dst = '0; ex_dst = '0; d_use_src = 0; d_use_dst = 0;
    ex_memRead = 0; ex_regWrite = 0; branch_taken = 0; mem_busy = 0; int_req = 0;

    // Reset state
    s = idle_stim(); s.rst = 0;
    apply_stimulus(s);
    apply_stimulus(s);
    apply_idle(2);

    // Load-use hazard, then bubble 2 carries a branch
    apply_stimulus(hz_stim());
    apply_idle(4);
    apply_stimulus(hz_stim());
    s = idle_stim(); s.branch_taken = 1;
    apply_stimulus(s);
    apply_idle(3);

    // Branch and hazard in the same cycle; hazard via destination field
    s = hz_stim(); s.branch_taken = 1;
    apply_stimulus(s);
    apply_idle(2);
    s = idle_stim(); s.ex_memRead = 1; s.ex_regWrite = 1; s.ex_dst = 3'd5;
    s.d_use_dst = 1; s.d_dst = 3'd5; s.d_src = 3'd5;
    apply_stimulus(s);
    apply_idle(4);

    // Interrupt pulse: drain, two pushes, vector
    s = idle_stim(); s.int_req = 1;
    apply_stimulus(s);
    apply_idle(10);

    // Memory stall between the two pushed words
    s = idle_stim(); s.int_req = 1;
    apply_stimulus(s);
    apply_idle(5);
    s = idle_stim(); s.mem_busy = 1;
    for (int i = 0; i < 4; i++) apply_stimulus(s);
    apply_idle(6);

    // Branch during drain, then reset during drain
    s = idle_stim(); s.int_req = 1;
    apply_stimulus(s);
    apply_idle(2);
    s = idle_stim(); s.branch_taken = 1;
    apply_stimulus(s);
    apply_idle(8);
    s = idle_stim(); s.int_req = 1;
    apply_stimulus(s);
    apply_idle(2);
    s = idle_stim(); s.rst = 0;
    apply_stimulus(s);
    apply_stimulus(s);
    apply_idle(6);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      s.rst          = ($urandom_range(0, 299) != 0);
      s.d_src        = N'($urandom_range(0, (1 << N) - 1));
      s.d_dst        = N'($urandom_range(0, (1 << N) - 1));
      s.ex_dst       = N'($urandom_range(0, (1 << N) - 1));
      s.d_use_src    = ($urandom_range(0, 1) == 1);
      s.d_use_dst    = ($urandom_range(0, 1) == 1);
      s.ex_memRead   = ($urandom_range(0, 9) < 6);
      s.ex_regWrite  = ($urandom_range(0, 9) < 6);
      s.branch_taken = ($urandom_range(0, 7) == 0);
      s.mem_busy     = ($urandom_range(0, 5) == 0);
      s.int_req      = ($urandom_range(0, 19) == 0);
      apply_stimulus(s);
    end
    apply_idle(12);

    wait_cycles = 0;
    while (sb.size() > 0 && wait_cycles < 10) begin
      @(negedge clk);
      wait_cycles++;
    end
    #5;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain got=%0d pending entries expected=0", sb.size());
    end
    checks++;
    if (dut_pushes_b != model_pushes_b) begin
      errors++;
      $display("[TB] FAIL push_count_b got=%0d expected=%0d", dut_pushes_b, model_pushes_b);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
